// File: rtl/robotron_mem_arbiter.sv
// Two-port arbiter for the shared async RAM/flash bus.
// Video has priority; a starvation counter bounds CPU wait.
module robotron_mem_arbiter #(
    parameter int ACCESS_CYCLES  = 4,
    parameter int CPU_STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_flash,
    input  logic [22:0] cpu_addr,
    input  logic [1:0]  cpu_be,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        vid_req,
    input  logic [22:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,
    output logic [22:0] MemAdr,
    output logic [15:0] MemDB_out,
    input  logic [15:0] MemDB_in,
    output logic        mem_drive,
    output logic        MemOE,
    output logic        MemWR,
    output logic        RamCS,
    output logic        FlashCS,
    output logic        RamLB,
    output logic        RamUB
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int SW = (CPU_STARVE_MAX > 0) ? $clog2(CPU_STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(ACCESS_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_MX = SW'(CPU_STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RECOVER
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          own_vid_q, own_vid_d;
    logic          we_q, we_d;
    logic          flash_q, flash_d;
    logic [22:0]   adr_q, adr_d;
    logic [15:0]   dbo_q, dbo_d;
    logic          drive_q, drive_d;
    logic          oe_q, oe_d;
    logic          wr_q, wr_d;
    logic          ramcs_q, ramcs_d;
    logic          flcs_q, flcs_d;
    logic          lb_q, lb_d;
    logic          ub_q, ub_d;
    logic          cack_q, cack_d;
    logic          vack_q, vack_d;
    logic [15:0]   crd_q, crd_d;
    logic [15:0]   vrd_q, vrd_d;
    logic          take_cpu;
    logic          take_vid;

    // Next-state and next-output logic; every bus pin is a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        starve_d  = starve_q;
        own_vid_d = own_vid_q;
        we_d      = we_q;
        flash_d   = flash_q;
        adr_d     = adr_q;
        dbo_d     = dbo_q;
        drive_d   = drive_q;
        oe_d      = oe_q;
        wr_d      = wr_q;
        ramcs_d   = ramcs_q;
        flcs_d    = flcs_q;
        lb_d      = lb_q;
        ub_d      = ub_q;
        cack_d    = 1'b0;
        vack_d    = 1'b0;
        crd_d     = crd_q;
        vrd_d     = vrd_q;
        take_cpu  = 1'b0;
        take_vid  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req && starve_q == STARVE_MX) begin
                    take_cpu = 1'b1;
                end else if (vid_req) begin
                    take_vid = 1'b1;
                end else if (cpu_req) begin
                    take_cpu = 1'b1;
                end

                if (take_cpu || !cpu_req) begin
                    starve_d = '0;
                end else if (take_vid && starve_q != STARVE_MX) begin
                    starve_d = starve_q + SW'(1);
                end

                if (take_vid) begin
                    state_d   = S_SETUP;
                    own_vid_d = 1'b1;
                    we_d      = 1'b0;
                    flash_d   = 1'b0;
                    adr_d     = vid_addr;
                    ramcs_d   = 1'b0;
                    flcs_d    = 1'b1;
                    lb_d      = 1'b0;
                    ub_d      = 1'b0;
                    drive_d   = 1'b0;
                end else if (take_cpu) begin
                    state_d   = S_SETUP;
                    own_vid_d = 1'b0;
                    we_d      = cpu_we;
                    flash_d   = cpu_flash;
                    adr_d     = cpu_addr;
                    ramcs_d   = cpu_flash;
                    flcs_d    = ~cpu_flash;
                    lb_d      = ~cpu_be[0];
                    ub_d      = ~cpu_be[1];
                    drive_d   = 1'b0;
                    if (cpu_we) begin
                        dbo_d   = cpu_wdata;
                        // flash is read-only: never drive the bus to it
                        drive_d = ~cpu_flash;
                    end
                end
            end

            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = CNT_LOAD;
                if (!we_q) begin
                    oe_d = 1'b0;
                end else if (!flash_q) begin
                    wr_d = 1'b0;
                end
            end

            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_RECOVER;
                    oe_d    = 1'b1;
                    wr_d    = 1'b1;
                    ramcs_d = 1'b1;
                    flcs_d  = 1'b1;
                    lb_d    = 1'b1;
                    ub_d    = 1'b1;
                    drive_d = 1'b0;
                    if (own_vid_q) begin
                        vack_d = 1'b1;
                        vrd_d  = MemDB_in;
                    end else begin
                        cack_d = 1'b1;
                        if (!we_q) begin
                            crd_d = MemDB_in;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_RECOVER: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            starve_q  <= '0;
            own_vid_q <= 1'b0;
            we_q      <= 1'b0;
            flash_q   <= 1'b0;
            adr_q     <= '0;
            dbo_q     <= '0;
            drive_q   <= 1'b0;
            oe_q      <= 1'b1;
            wr_q      <= 1'b1;
            ramcs_q   <= 1'b1;
            flcs_q    <= 1'b1;
            lb_q      <= 1'b1;
            ub_q      <= 1'b1;
            cack_q    <= 1'b0;
            vack_q    <= 1'b0;
            crd_q     <= '0;
            vrd_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            own_vid_q <= own_vid_d;
            we_q      <= we_d;
            flash_q   <= flash_d;
            adr_q     <= adr_d;
            dbo_q     <= dbo_d;
            drive_q   <= drive_d;
            oe_q      <= oe_d;
            wr_q      <= wr_d;
            ramcs_q   <= ramcs_d;
            flcs_q    <= flcs_d;
            lb_q      <= lb_d;
            ub_q      <= ub_d;
            cack_q    <= cack_d;
            vack_q    <= vack_d;
            crd_q     <= crd_d;
            vrd_q     <= vrd_d;
        end
    end

    assign MemAdr    = adr_q;
    assign MemDB_out = dbo_q;
    assign mem_drive = drive_q;
    assign MemOE     = oe_q;
    assign MemWR     = wr_q;
    assign RamCS     = ramcs_q;
    assign FlashCS   = flcs_q;
    assign RamLB     = lb_q;
    assign RamUB     = ub_q;
    assign cpu_ack   = cack_q;
    assign cpu_rdata = crd_q;
    assign vid_ack   = vack_q;
    assign vid_rdata = vrd_q;

    // Bus contention guards: one chip select, one strobe direction.
    a_one_cs : assert property (@(posedge clk) disable iff (reset)
        !(!ramcs_q && !flcs_q));
    a_one_strobe : assert property (@(posedge clk) disable iff (reset)
        !(!oe_q && !wr_q));

endmodule

// File: tb/tb_robotron_mem_arbiter.sv
// Bench for robotron_mem_arbiter: vector table of single
// accesses plus starvation and mid-access reset sequences.
module tb_robotron_mem_arbiter;

    localparam int AC = 4;
    localparam int SM = 3;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_flash;
    logic [22:0] cpu_addr;
    logic [1:0]  cpu_be;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        vid_req;
    logic [22:0] vid_addr;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic [22:0] MemAdr;
    logic [15:0] MemDB_out;
    logic [15:0] MemDB_in;
    logic        mem_drive;
    logic        MemOE;
    logic        MemWR;
    logic        RamCS;
    logic        FlashCS;
    logic        RamLB;
    logic        RamUB;

    robotron_mem_arbiter #(
        .ACCESS_CYCLES (AC),
        .CPU_STARVE_MAX(SM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_flash(cpu_flash),
        .cpu_addr (cpu_addr),
        .cpu_be   (cpu_be),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .vid_rdata(vid_rdata),
        .MemAdr   (MemAdr),
        .MemDB_out(MemDB_out),
        .MemDB_in (MemDB_in),
        .mem_drive(mem_drive),
        .MemOE    (MemOE),
        .MemWR    (MemWR),
        .RamCS    (RamCS),
        .FlashCS  (FlashCS),
        .RamLB    (RamLB),
        .RamUB    (RamUB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        vid;
        logic        we;
        logic        fl;
        logic [22:0] adr;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [15:0] db;
        logic        e_ram;
        logic        e_fl;
        logic        e_lb;
        logic        e_ub;
        logic        e_oe;
        logic        e_wr;
        logic        e_drv;
        logic [15:0] e_crd;
        logic [15:0] e_vrd;
    } vec_t;

    vec_t vt [7];
    vec_t rv;
    int   n_chk;
    int   n_fail;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        if (v.vid) begin
            vid_req  = 1'b1;
            vid_addr = v.adr;
        end else begin
            cpu_req   = 1'b1;
            cpu_we    = v.we;
            cpu_flash = v.fl;
            cpu_addr  = v.adr;
            cpu_be    = v.be;
            cpu_wdata = v.wd;
        end
        MemDB_in = ~v.db;
        for (int k = 1; k <= AC + 2; k++) begin
            tick();
            MemDB_in = (k == AC + 1) ? v.db : ~v.db;
            if (k <= AC + 1) begin
                chk("ramcs", RamCS, v.e_ram);
                chk("flashcs", FlashCS, v.e_fl);
                chk("lb", RamLB, v.e_lb);
                chk("ub", RamUB, v.e_ub);
                chk("adr", MemAdr, v.adr);
                chk("drive", mem_drive, v.e_drv);
                if (v.e_drv) chk("dbout", MemDB_out, v.wd);
                chk("oe", MemOE, (k >= 2) ? v.e_oe : 1'b1);
                chk("wr", MemWR, (k >= 2) ? v.e_wr : 1'b1);
            end else begin
                chk("rec_ramcs", RamCS, 1'b1);
                chk("rec_flashcs", FlashCS, 1'b1);
                chk("rec_oe", MemOE, 1'b1);
                chk("rec_wr", MemWR, 1'b1);
                chk("rec_drive", mem_drive, 1'b0);
                chk("cpu_rdata", cpu_rdata, v.e_crd);
                chk("vid_rdata", vid_rdata, v.e_vrd);
            end
            chk("cpu_ack", cpu_ack, (k == AC + 2) && !v.vid);
            chk("vid_ack", vid_ack, (k == AC + 2) && v.vid);
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
        tick();
        chk("idle_cack", cpu_ack, 1'b0);
        chk("idle_vack", vid_ack, 1'b0);
        chk("idle_ramcs", RamCS, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  nacks;
        int  last_cyc;
        int  cyc;
        int  got;
        int  bad;
        n_chk  = 0;
        n_fail = 0;

        vt[0] = '{1'b0, 1'b0, 1'b0, 23'h001234, 2'b11, 16'h0000,
                  16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 16'hBEEF, 16'h0000};
        vt[1] = '{1'b0, 1'b1, 1'b0, 23'h000010, 2'b01, 16'hA55A,
                  16'h1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                  1'b1, 16'hBEEF, 16'h0000};
        vt[2] = '{1'b0, 1'b1, 1'b1, 23'h400000, 2'b11, 16'h1234,
                  16'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                  1'b0, 16'hBEEF, 16'h0000};
        vt[3] = '{1'b1, 1'b0, 1'b0, 23'h000ABC, 2'b00, 16'h0000,
                  16'h5A5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 16'hBEEF, 16'h5A5A};
        vt[4] = '{1'b0, 1'b1, 1'b0, 23'h000020, 2'b00, 16'hFFFF,
                  16'h3333, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                  1'b1, 16'hBEEF, 16'h5A5A};
        vt[5] = '{1'b0, 1'b0, 1'b1, 23'h400123, 2'b10, 16'h0000,
                  16'hCAFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                  1'b0, 16'hCAFE, 16'h5A5A};
        vt[6] = '{1'b1, 1'b0, 1'b0, 23'h7FFFFF, 2'b11, 16'h0000,
                  16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 16'hCAFE, 16'h0001};
        rv    = '{1'b1, 1'b0, 1'b0, 23'h000321, 2'b11, 16'h0000,
                  16'h4321, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 16'h0000, 16'h4321};

        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_flash = 1'b0;
        cpu_addr  = '0;
        cpu_be    = '0;
        cpu_wdata = '0;
        vid_req   = 1'b0;
        vid_addr  = '0;
        MemDB_in  = 16'hDEAD;
        tick();
        tick();
        chk("rst_oe", MemOE, 1'b1);
        chk("rst_wr", MemWR, 1'b1);
        chk("rst_ramcs", RamCS, 1'b1);
        chk("rst_flashcs", FlashCS, 1'b1);
        chk("rst_lbub", {RamLB, RamUB}, 2'b11);
        chk("rst_adr", MemAdr, 23'h0);
        chk("rst_dbout", MemDB_out, 16'h0);
        chk("rst_drive", mem_drive, 1'b0);
        chk("rst_acks", {cpu_ack, vid_ack}, 2'b00);
        chk("rst_rdata", {cpu_rdata, vid_rdata}, 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Both requesters held: expect V,V,V,C repeating.
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_flash = 1'b0;
        cpu_addr  = 23'h000055;
        cpu_be    = 2'b11;
        vid_req   = 1'b1;
        vid_addr  = 23'h000066;
        MemDB_in  = 16'h0F0F;
        nacks     = 0;
        last_cyc  = 0;
        bad       = 0;
        for (cyc = 1; cyc <= 8 * (AC + 3) + 20 && nacks < 8; cyc++) begin
            tick();
            if (cpu_ack && vid_ack) bad++;
            if (cpu_ack || vid_ack) begin
                got = cpu_ack ? 1 : 0;
                chk("grant_order", got, ((nacks % (SM + 1)) == SM) ? 1 : 0);
                chk("grant_adr", MemAdr,
                    cpu_ack ? 23'h000055 : 23'h000066);
                if (cpu_ack) chk("starve_rdata", cpu_rdata, 16'h0F0F);
                if (nacks > 0) chk("ack_spacing", cyc - last_cyc, AC + 3);
                last_cyc = cyc;
                nacks++;
            end
        end
        chk("starve_nacks", nacks, 8);
        chk("dual_ack", bad, 0);
        cpu_req = 1'b0;
        vid_req = 1'b0;
        tick();
        tick();

        // Reset in the middle of a video access drops it.
        vid_req  = 1'b1;
        vid_addr = 23'h000777;
        tick();
        tick();
        tick();
        chk("pre_rst_oe", MemOE, 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_rst_strobes", {MemOE, MemWR, RamCS, FlashCS}, 4'hF);
        chk("mid_rst_lanes", {RamLB, RamUB}, 2'b11);
        chk("mid_rst_adr", MemAdr, 23'h0);
        chk("mid_rst_drive", mem_drive, 1'b0);
        chk("mid_rst_acks", {cpu_ack, vid_ack}, 2'b00);
        chk("mid_rst_rdata", vid_rdata, 16'h0);
        reset   = 1'b0;
        vid_req = 1'b0;
        bad     = 0;
        for (int i = 0; i < AC + 4; i++) begin
            tick();
            if (cpu_ack || vid_ack) bad++;
        end
        chk("post_rst_noack", bad, 0);
        run_vec(rv);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
